// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared widths, RAM command and arbiter state types for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_cmd_t;

    // Owner of the read currently returning data from the RAM
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        F_RD = 2'd1,
        D_RD = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : starve_ctr
// Brief    : Saturating count of consecutive cycles the fetch port lost to data.
// Revision : 1.0 - initial release
// ============================================================================
module starve_ctr #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_f_req,
    input  logic i_f_gnt,
    input  logic i_d_gnt,
    output logic o_starved
);

    localparam int c_CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(STARVE_MAX);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_f_gnt || !i_f_req) begin
            r_cnt <= '0;
        end else if (i_d_gnt && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_starved = (r_cnt == c_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Fetch/data arbiter for one single-port RAM, data port has priority.
//            Define MEM_ARB_FAIRNESS_EN to force fetch after STARVE_MAX losses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_cmd,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       w_force_f;

`ifdef MEM_ARB_FAIRNESS_EN
    logic w_starved;

    starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk       (clk),
        .rst       (reset),
        .i_f_req   (f_req),
        .i_f_gnt   (f_gnt),
        .i_d_gnt   (d_gnt),
        .o_starved (w_starved)
    );

    assign w_force_f = w_starved & f_req & d_req;
`else
    logic w_unused_starve;

    assign w_unused_starve = (STARVE_MAX != 0);
    assign w_force_f       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        d_gnt       = 1'b0;
        f_gnt       = 1'b0;
        mem_addr    = '0;
        mem_cmd     = MEM_NONE;
        mem_wdata   = '0;
        w_state_nxt = IDLE;

        // Grants are suppressed while reset is high so no request leaks through
        d_gnt = d_req & ~reset & ~w_force_f;
        f_gnt = f_req & ~reset & ~d_gnt;

        if (f_gnt) begin
            mem_addr    = f_addr;
            mem_cmd     = MEM_READ;
            w_state_nxt = F_RD;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            if (d_we) begin
                mem_cmd = MEM_WRITE;
            end else begin
                mem_cmd     = MEM_READ;
                w_state_nxt = D_RD;
            end
        end
    end

    // Gating with reset drops a read that was in flight when reset arrived
    assign f_rvalid = (r_state == F_RD) & ~reset;
    assign d_rvalid = (r_state == D_RD) & ~reset;
    assign f_rdata  = f_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed and random checks of mem_arbiter against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int STARVE_MAX = 3;
`ifdef MEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [8:0]  f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [8:0]  d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic [8:0]  mem_addr;
    logic [1:0]  mem_cmd;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_cmd   (mem_cmd),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural single-port RAM attached to the arbiter
    logic [15:0] ram [512];
    always @(posedge clk) begin
        if (mem_cmd == MEM_READ)       mem_rdata <= ram[mem_addr];
        else if (mem_cmd == MEM_WRITE) ram[mem_addr] <= mem_wdata;
    end

    // Reference model state
    logic [15:0] ref_mem [512];
    int          starve;
    int          owner;          // 0 none, 1 fetch, 2 data
    logic [15:0] pend_data;
    bit          exp_f, exp_d;

    // Values seen at the last sample point
    logic        obs_fg, obs_dg, obs_fv, obs_dv;
    logic [1:0]  obs_cmd;
    logic [15:0] obs_fr, obs_dr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_cycle();
        bit          force_f;
        logic [1:0]  e_cmd;
        logic [8:0]  e_addr;
        logic [15:0] e_wd;
        bit          e_fv, e_dv;
        @(negedge clk);
        force_f = FAIR && (starve == STARVE_MAX) && f_req && d_req;
        exp_d   = d_req && !reset && !force_f;
        exp_f   = f_req && !reset && !exp_d;
        e_cmd   = exp_f ? 2'd1 : (exp_d ? (d_we ? 2'd2 : 2'd1) : 2'd0);
        e_addr  = exp_f ? f_addr : (exp_d ? d_addr : 9'd0);
        e_wd    = exp_d ? d_wdata : 16'd0;
        e_fv    = (owner == 1) && !reset;
        e_dv    = (owner == 2) && !reset;
        obs_fg = f_gnt; obs_dg = d_gnt; obs_cmd = mem_cmd;
        obs_fv = f_rvalid; obs_dv = d_rvalid; obs_fr = f_rdata; obs_dr = d_rdata;
        chk("f_gnt",     16'(f_gnt),     16'(exp_f));
        chk("d_gnt",     16'(d_gnt),     16'(exp_d));
        chk("mem_cmd",   16'(mem_cmd),   16'(e_cmd));
        chk("mem_addr",  16'(mem_addr),  16'(e_addr));
        chk("mem_wdata", mem_wdata,      e_wd);
        chk("f_rvalid",  16'(f_rvalid),  16'(e_fv));
        chk("d_rvalid",  16'(d_rvalid),  16'(e_dv));
        chk("f_rdata",   f_rdata,        e_fv ? pend_data : 16'd0);
        chk("d_rdata",   d_rdata,        e_dv ? pend_data : 16'd0);
        @(posedge clk);
        if (reset) begin
            owner  = 0;
            starve = 0;
        end else begin
            owner = 0;
            if (exp_f) begin
                owner = 1; pend_data = ref_mem[f_addr];
            end else if (exp_d && !d_we) begin
                owner = 2; pend_data = ref_mem[d_addr];
            end
            if (exp_d && d_we) ref_mem[d_addr] = d_wdata;
            if (!f_req || exp_f)  starve = 0;
            else if (exp_d && starve < STARVE_MAX) starve = starve + 1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram[i]     = 16'(i * 37 + 5);
            ref_mem[i] = 16'(i * 37 + 5);
        end
        ram[5] = 16'hA0B1; ref_mem[5] = 16'hA0B1;
        mem_rdata = '0;
        owner = 0; starve = 0; pend_data = '0;
        reset = 1'b1; f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        @(posedge clk); #1;

        // Requests during reset must not be granted
        f_req = 1; d_req = 1; f_addr = 9'h001; d_addr = 9'h002;
        run_cycle();
        chk("rst_no_fgnt", 16'(obs_fg), 16'd0);
        chk("rst_no_dgnt", 16'(obs_dg), 16'd0);
        chk("rst_cmd",     16'(obs_cmd), 16'(MEM_NONE));
        reset = 0; f_req = 0; d_req = 0;
        run_cycle();
        chk("post_rst_fv", 16'(obs_fv), 16'd0);
        chk("post_rst_dv", 16'(obs_dv), 16'd0);

        // Fetch-only read
        f_req = 1; f_addr = 9'h005;
        run_cycle();
        chk("fo_gnt", 16'(obs_fg), 16'd1);
        chk("fo_cmd", 16'(obs_cmd), 16'(MEM_READ));
        f_req = 0;
        run_cycle();
        chk("fo_rvalid", 16'(obs_fv), 16'd1);
        chk("fo_rdata",  obs_fr, 16'hA0B1);

        // Collision: data write beats fetch, fetch wins the next cycle
        f_req = 1; f_addr = 9'h007; d_req = 1; d_we = 1; d_addr = 9'h010; d_wdata = 16'h1234;
        run_cycle();
        chk("col_dgnt", 16'(obs_dg), 16'd1);
        chk("col_fgnt", 16'(obs_fg), 16'd0);
        chk("col_cmd",  16'(obs_cmd), 16'(MEM_WRITE));
        d_req = 0; d_we = 0;
        run_cycle();
        chk("col_fgnt2", 16'(obs_fg), 16'd1);
        chk("col_no_dv", 16'(obs_dv), 16'd0);
        f_req = 0;
        run_cycle();
        chk("col_no_dv2", 16'(obs_dv), 16'd0);

        // Starvation: both ports request reads continuously
        f_req = 1; f_addr = 9'h008; d_req = 1; d_we = 0; d_addr = 9'h009;
        for (int k = 0; k < 4; k++) begin
            run_cycle();
            chk($sformatf("starve_fgnt%0d", k), 16'(obs_fg), 16'(FAIR && k == 3));
            chk($sformatf("starve_dgnt%0d", k), 16'(obs_dg), 16'(!(FAIR && k == 3)));
        end
        f_req = 0; d_req = 0;
        run_cycle();

        // Back-to-back: data read then fetch read
        d_req = 1; d_we = 0; d_addr = 9'h020;
        run_cycle();
        chk("b2b_dgnt", 16'(obs_dg), 16'd1);
        d_req = 0; f_req = 1; f_addr = 9'h000;
        run_cycle();
        chk("b2b_dv",    16'(obs_dv), 16'd1);
        chk("b2b_drd",   obs_dr, 16'h04A5);
        chk("b2b_fgnt",  16'(obs_fg), 16'd1);
        f_req = 0;
        run_cycle();
        chk("b2b_fv",    16'(obs_fv), 16'd1);
        chk("b2b_frd",   obs_fr, 16'h0005);

        // Reset while a fetch read is in flight
        f_req = 1; f_addr = 9'h003;
        run_cycle();
        chk("rmr_fgnt", 16'(obs_fg), 16'd1);
        reset = 1; f_req = 0;
        run_cycle();
        chk("rmr_fv",  16'(obs_fv), 16'd0);
        chk("rmr_cmd", 16'(obs_cmd), 16'(MEM_NONE));
        reset = 0;
        run_cycle();
        chk("rmr_fv2", 16'(obs_fv), 16'd0);

        // Random traffic honouring the hold-until-granted rule
        for (int n = 0; n < 400; n++) begin
            if (!f_req || exp_f) begin
                f_req  = ($urandom_range(0, 2) != 0);
                f_addr = 9'($urandom_range(0, 15));
            end else if ($urandom_range(0, 9) == 0) begin
                f_req = 0;
            end
            if (!d_req || exp_d) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 9'($urandom_range(0, 15));
                d_wdata = 16'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                d_req = 0;
            end
            reset = ($urandom_range(0, 49) == 0);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
